seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
Monitors a multiplexed, active-low 4-digit 7-segment bus (segments + segsel) and reconstructs the 16-bit hex value being displayed. It is the receive-side counterpart of the display scan driver. Uses: self-check of display paths, and capture of 7-seg output from external boards. Output is a registered 16-bit number plus a frame-complete pulse, a valid level and error pulses.

Parameters:
SETTLE_CYCLES, 16, consecutive identical samples required before a digit is accepted (min 2).
SCAN_TIMEOUT, 200000, cycles without an accepted digit before numValid drops (min SETTLE_CYCLES+4).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
segments  input  7  active-low segment drive; after inversion, bit0=a … bit6=g
segsel  input  4  active-low digit select; bit0 = digit 0 (dispNum[3:0]) … bit3 = digit 3 (dispNum[15:12])
dispNum  output  16  last fully reconstructed value
numValid  output  1  high while dispNum reflects a complete, error-free, non-stale frame
newFrame  output  1  one-cycle pulse when dispNum is updated
glyphErr  output  1  one-cycle pulse when an accepted digit has an unrecognised pattern
selErr  output  1  one-cycle pulse when an accepted segsel is neither one-hot-low nor 4'b1111

Behaviour:
- Reset (sync, active-high): dispNum=0, numValid=0, newFrame=0, glyphErr=0, selErr=0. Capture mask and all counters cleared. Sync registers loaded with idle values segsel=4'b1111, segments=7'h7F. Reset mid-frame discards partial captures.
- Input path: {segsel,segments} pass through two registers, s1 then s2.
- Settle counter:
  - Increments, saturating at SETTLE_CYCLES, while s1==s2.
  - Clears to 0 when s1!=s2.
  - An accept event fires exactly once per stable period: on the cycle the counter transitions to SETTLE_CYCLES.
- Latency: inputs stable from cycle t. Accept is evaluated at cycle t+SETTLE_CYCLES+2. Registered results (newFrame, errors, dispNum) are visible at t+SETTLE_CYCLES+3.
- Accept handling, applied to s2:
  - segsel==4'b1111 (blank): ignored. No error, timeout counter not reset.
  - segsel not exactly one zero: selErr pulse. Mask and staging unchanged.
  - Valid select: decode p=~segments against the fixed glyph table (hex, gfedcba):
    - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
    - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Match: write nibble to staging[digit], set mask[digit], reset timeout counter.
  - No match: glyphErr pulse, clear mask[digit], do not reset timeout counter.
  - Repeated capture of an already-captured digit overwrites its nibble.
- Frame completion:
  - Triggered in the same cycle an accept makes mask==4'b1111.
  - dispNum <= staging including the new nibble; newFrame=1 for one cycle; numValid=1; mask cleared.
  - Capture order is irrelevant.
- Timeout:
  - Counter increments every cycle and saturates.
  - On reaching SCAN_TIMEOUT: numValid=0 and mask cleared. dispNum holds its last value.
  - If an accept and the timeout fall in the same cycle, the accept wins: counter resets and the frame may complete.
- Error and valid interaction: glyphErr and selErr do not clear numValid directly. numValid is lowered only by timeout or reset. A bad digit only blocks the next frame from completing.
- Pulse outputs are never high for two consecutive cycles from a single accept.

Test Plan:
- Clean scan: SETTLE=16, drive digits 0..3 of 16'h1A2F (digit0 p=71, digit1 p=5B, digit2 p=77, digit3 p=06, sent inverted) for 50 cycles each → single newFrame pulse 19 cycles after digit 3 stable, dispNum=16'h1A2F, numValid=1, no error pulses.
- Glitch rejection: during steady digit1=5, insert a 10-cycle segsel=4'b1011 with p=7F → not accepted. Completed frame value unchanged from the pre-glitch scan.
- Bad glyph: digit2 p=7'h00 → glyphErr pulse once. No newFrame until digit2 is re-sent valid; then newFrame fires with the corrected nibble.
- Bad select: segsel=4'b1100 held 40 cycles → exactly one selErr pulse. segsel=4'b1111 held 40 cycles → no pulse.
- Timeout: after a valid frame, hold blank → numValid falls exactly SCAN_TIMEOUT cycles after the last accept. dispNum holds 16'h1A2F.
- Reset mid-frame: capture digits 0,1, assert rst 1 cycle, send digits 2,3 → no newFrame. A full subsequent scan completes normally.

Source files
------------

// File: rtl/seg7_scan_decoder_if.sv
// rtl/seg7_scan_decoder_if.sv - multiplexed 7-segment bus plus reconstructed-value outputs
interface seg7_scan_decoder_if;
  logic [6:0]  segments;
  logic [3:0]  segsel;
  logic [15:0] dispNum;
  logic        numValid;
  logic        newFrame;
  logic        glyphErr;
  logic        selErr;

  modport master (
    output segments,
    output segsel,
    input  dispNum,
    input  numValid,
    input  newFrame,
    input  glyphErr,
    input  selErr
  );

  modport slave (
    input  segments,
    input  segsel,
    output dispNum,
    output numValid,
    output newFrame,
    output glyphErr,
    output selErr
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - rebuilds a 16-bit hex value from an active-low scanned 4-digit 7-seg bus
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES = 16,
  parameter int SCAN_TIMEOUT  = 200000
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_decoder_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(SCAN_TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_MAX   = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(SCAN_TIMEOUT);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(SCAN_TIMEOUT - 1);
  localparam logic [10:0]   IDLE_WORD    = {4'b1111, 7'h7F};

  logic [10:0]   s1;
  logic [10:0]   s2;
  logic [10:0]   acc_word;
  logic          acc;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] idle_cnt;
  logic [3:0]    mask;
  logic [15:0]   staging;

  logic [15:0]   disp_num_q;
  logic          num_valid_q;
  logic          new_frame_q;
  logic          glyph_err_q;
  logic          sel_err_q;

  logic [3:0]    acc_sel;
  logic [6:0]    acc_pat;
  logic          sel_blank;
  logic          sel_onehot;
  logic [1:0]    digit;
  logic          glyph_hit;
  logic [3:0]    glyph_nib;
  logic          good;
  logic [15:0]   staging_upd;
  logic [3:0]    mask_upd;
  logic          timeout_hit;

  // Returns {hit, nibble}; p is the active-high pattern in gfedcba order.
  function automatic logic [4:0] glyph_decode(input logic [6:0] p);
    case (p)
      7'h3F:   return {1'b1, 4'h0};
      7'h06:   return {1'b1, 4'h1};
      7'h5B:   return {1'b1, 4'h2};
      7'h4F:   return {1'b1, 4'h3};
      7'h66:   return {1'b1, 4'h4};
      7'h6D:   return {1'b1, 4'h5};
      7'h7D:   return {1'b1, 4'h6};
      7'h07:   return {1'b1, 4'h7};
      7'h7F:   return {1'b1, 4'h8};
      7'h6F:   return {1'b1, 4'h9};
      7'h77:   return {1'b1, 4'hA};
      7'h7C:   return {1'b1, 4'hB};
      7'h39:   return {1'b1, 4'hC};
      7'h5E:   return {1'b1, 4'hD};
      7'h79:   return {1'b1, 4'hE};
      7'h71:   return {1'b1, 4'hF};
      default: return 5'h00;
    endcase
  endfunction

  always_comb begin
    acc_sel    = acc_word[10:7];
    acc_pat    = ~acc_word[6:0];
    sel_blank  = (acc_sel == 4'b1111);
    sel_onehot = 1'b1;
    digit      = 2'd0;
    case (acc_sel)
      4'b1110: digit = 2'd0;
      4'b1101: digit = 2'd1;
      4'b1011: digit = 2'd2;
      4'b0111: digit = 2'd3;
      default: sel_onehot = 1'b0;
    endcase
    {glyph_hit, glyph_nib} = glyph_decode(acc_pat);
    good        = acc && sel_onehot && glyph_hit;
    staging_upd = staging;
    staging_upd[{digit, 2'b00} +: 4] = glyph_nib;
    mask_upd    = mask | (4'b0001 << digit);
    // A good accept in the expiry cycle restarts the window instead of timing out.
    timeout_hit = (idle_cnt == TIMEOUT_LAST) && !good;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= IDLE_WORD;
      s2          <= IDLE_WORD;
      acc_word    <= IDLE_WORD;
      acc         <= 1'b0;
      settle_cnt  <= '0;
      idle_cnt    <= '0;
      mask        <= 4'b0000;
      staging     <= 16'h0000;
      disp_num_q  <= 16'h0000;
      num_valid_q <= 1'b0;
      new_frame_q <= 1'b0;
      glyph_err_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      s1 <= {bus.segsel, bus.segments};
      s2 <= s1;

      if (s1 != s2) begin
        settle_cnt <= '0;
      end else if (settle_cnt != SETTLE_MAX) begin
        settle_cnt <= settle_cnt + SW'(1);
      end
      // Fires only on the transition into saturation, so once per stable period.
      acc      <= (s1 == s2) && (settle_cnt == SETTLE_LAST);
      acc_word <= s2;

      new_frame_q <= 1'b0;
      glyph_err_q <= 1'b0;
      sel_err_q   <= 1'b0;

      if (good) begin
        idle_cnt <= '0;
      end else if (idle_cnt != TIMEOUT_MAX) begin
        idle_cnt <= idle_cnt + TW'(1);
      end

      if (timeout_hit) begin
        num_valid_q <= 1'b0;
        mask        <= 4'b0000;
      end

      if (acc && !sel_blank) begin
        if (!sel_onehot) begin
          sel_err_q <= 1'b1;
        end else if (glyph_hit) begin
          staging <= staging_upd;
          if (mask_upd == 4'b1111) begin
            disp_num_q  <= staging_upd;
            new_frame_q <= 1'b1;
            num_valid_q <= 1'b1;
            mask        <= 4'b0000;
          end else begin
            mask <= mask_upd;
          end
        end else begin
          glyph_err_q  <= 1'b1;
          mask[digit]  <= 1'b0;
        end
      end
    end
  end

  assign bus.dispNum  = disp_num_q;
  assign bus.numValid = num_valid_q;
  assign bus.newFrame = new_frame_q;
  assign bus.glyphErr = glyph_err_q;
  assign bus.selErr   = sel_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;
  localparam int S = 16;
  localparam int T = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_decoder_if bus();

  seg7_scan_decoder #(.SETTLE_CYCLES(S), .SCAN_TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [15:0] frames_q [$];
  int glyph_seen = 0;
  int sel_seen = 0;
  int double_pulse = 0;
  logic prev_nf = 1'b0, prev_ge = 1'b0, prev_se = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_nf = 1'b0; prev_ge = 1'b0; prev_se = 1'b0;
    end else begin
      if (bus.newFrame) frames_q.push_back(bus.dispNum);
      if (bus.glyphErr) glyph_seen++;
      if (bus.selErr) sel_seen++;
      if ((bus.newFrame && prev_nf) || (bus.glyphErr && prev_ge) || (bus.selErr && prev_se))
        double_pulse++;
      prev_nf = bus.newFrame; prev_ge = bus.glyphErr; prev_se = bus.selErr;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] sel_of(input int d);
    logic [3:0] v;
    v = 4'b0001 << d;
    return ~v;
  endfunction

  function automatic int glyph_index(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic send(input logic [3:0] sel, input logic [6:0] p, input int n);
    @(posedge clk); #1;
    bus.segsel = sel;
    bus.segments = ~p;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send_digit(input int d, input logic [3:0] nib, input int n);
    send(sel_of(d), glyph_tab[nib], n);
  endtask

  task automatic send_value(input logic [15:0] val, input int n);
    for (int d = 0; d < 4; d++) send_digit(d, val[d*4 +: 4], n);
  endtask

  task automatic clear_mon();
    frames_q.delete();
    glyph_seen = 0;
    sel_seen = 0;
    double_pulse = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.segsel = 4'hF;
    bus.segments = 7'h7F;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total_cnt++; if (bus.dispNum !== 16'h0) $display("FAIL reset_dispNum got %h want 0000", bus.dispNum); else pass_cnt++;
    total_cnt++; if (bus.numValid !== 1'b0) $display("FAIL reset_numValid got %b want 0", bus.numValid); else pass_cnt++;
    total_cnt++; if (bus.newFrame !== 1'b0) $display("FAIL reset_newFrame got %b want 0", bus.newFrame); else pass_cnt++;
    total_cnt++; if (bus.glyphErr !== 1'b0) $display("FAIL reset_glyphErr got %b want 0", bus.glyphErr); else pass_cnt++;
    total_cnt++; if (bus.selErr !== 1'b0) $display("FAIL reset_selErr got %b want 0", bus.selErr); else pass_cnt++;
  endtask

  task automatic test_clean_scan();
    int lat;
    clear_mon();
    send_digit(0, 4'hF, 50);
    send_digit(1, 4'h2, 50);
    send_digit(2, 4'hA, 50);
    @(posedge clk); #1;
    bus.segsel = sel_of(3);
    bus.segments = ~glyph_tab[1];
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.newFrame && lat < 0) lat = i;
    end
    total_cnt++; if (lat !== S + 3) $display("FAIL clean_latency got %0d want %0d", lat, S + 3); else pass_cnt++;
    total_cnt++; if (bus.dispNum !== 16'h1A2F) $display("FAIL clean_dispNum got %h want 1a2f", bus.dispNum); else pass_cnt++;
    total_cnt++; if (bus.numValid !== 1'b1) $display("FAIL clean_numValid got %b want 1", bus.numValid); else pass_cnt++;
    total_cnt++; if (frames_q.size() != 1) $display("FAIL clean_frames got %0d want 1", frames_q.size()); else pass_cnt++;
    total_cnt++; if (glyph_seen + sel_seen != 0) $display("FAIL clean_errors got %0d want 0", glyph_seen + sel_seen); else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic [15:0] got;
    clear_mon();
    send_digit(0, 4'h3, 30);
    send_digit(1, 4'h5, 30);
    send(4'b1011, 7'h7F, 10);
    send_digit(1, 4'h5, 30);
    send_digit(2, 4'hC, 30);
    send_digit(3, 4'h7, 30);
    send(4'hF, 7'h00, 30);
    got = (frames_q.size() > 0) ? frames_q[0] : 16'hxxxx;
    total_cnt++; if (frames_q.size() != 1) $display("FAIL glitch_frames got %0d want 1", frames_q.size()); else pass_cnt++;
    total_cnt++; if (got !== 16'h7C53) $display("FAIL glitch_value got %h want 7c53", got); else pass_cnt++;
    total_cnt++; if (glyph_seen + sel_seen != 0) $display("FAIL glitch_errors got %0d want 0", glyph_seen + sel_seen); else pass_cnt++;
  endtask

  task automatic test_bad_glyph();
    logic [15:0] got;
    clear_mon();
    send_digit(0, 4'h4, 30);
    send_digit(1, 4'h0, 30);
    send(sel_of(2), 7'h00, 30);
    send_digit(3, 4'h9, 30);
    send(4'hF, 7'h00, 30);
    total_cnt++; if (glyph_seen != 1) $display("FAIL badglyph_count got %0d want 1", glyph_seen); else pass_cnt++;
    total_cnt++; if (frames_q.size() != 0) $display("FAIL badglyph_blocked got %0d want 0", frames_q.size()); else pass_cnt++;
    total_cnt++; if (bus.numValid !== 1'b1) $display("FAIL badglyph_numValid got %b want 1", bus.numValid); else pass_cnt++;
    send_digit(2, 4'hE, 30);
    send(4'hF, 7'h00, 30);
    got = (frames_q.size() > 0) ? frames_q[0] : 16'hxxxx;
    total_cnt++; if (frames_q.size() != 1) $display("FAIL badglyph_resend_frames got %0d want 1", frames_q.size()); else pass_cnt++;
    total_cnt++; if (got !== 16'h9E04) $display("FAIL badglyph_value got %h want 9e04", got); else pass_cnt++;
  endtask

  task automatic test_bad_select();
    clear_mon();
    send(4'b1100, 7'h06, 40);
    total_cnt++; if (sel_seen != 1) $display("FAIL badsel_count got %0d want 1", sel_seen); else pass_cnt++;
    send(4'b1111, 7'h06, 40);
    total_cnt++; if (sel_seen != 1) $display("FAIL blank_selErr got %0d want 1", sel_seen); else pass_cnt++;
    total_cnt++; if (glyph_seen != 0) $display("FAIL blank_glyphErr got %0d want 0", glyph_seen); else pass_cnt++;
  endtask

  task automatic test_settle_boundary();
    logic [15:0] got;
    clear_mon();
    send_digit(0, 4'hB, 30);
    send_digit(1, 4'hD, 30);
    send_digit(2, 4'h8, 30);
    send_digit(3, 4'h6, S);
    send(4'hF, 7'h00, 30);
    total_cnt++; if (frames_q.size() != 0) $display("FAIL settle_short got %0d want 0", frames_q.size()); else pass_cnt++;
    send_digit(3, 4'h6, S + 1);
    send(4'hF, 7'h00, 30);
    got = (frames_q.size() > 0) ? frames_q[0] : 16'hxxxx;
    total_cnt++; if (frames_q.size() != 1) $display("FAIL settle_exact got %0d want 1", frames_q.size()); else pass_cnt++;
    total_cnt++; if (got !== 16'h68DB) $display("FAIL settle_value got %h want 68db", got); else pass_cnt++;
  endtask

  task automatic test_timeout();
    bit seen;
    clear_mon();
    send_digit(0, 4'hF, 30);
    send_digit(1, 4'h2, 30);
    send_digit(2, 4'hA, 30);
    @(posedge clk); #1;
    bus.segsel = sel_of(3);
    bus.segments = ~glyph_tab[1];
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.newFrame) seen = 1'b1;
    end
    total_cnt++; if (!seen) $display("FAIL timeout_frame got none want newFrame"); else pass_cnt++;
    bus.segsel = 4'hF;
    bus.segments = 7'h7F;
    for (int k = 1; k <= T; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == T - 1) begin
        total_cnt++; if (bus.numValid !== 1'b1) $display("FAIL timeout_before got %b want 1", bus.numValid); else pass_cnt++;
      end
      if (k == T) begin
        total_cnt++; if (bus.numValid !== 1'b0) $display("FAIL timeout_at got %b want 0", bus.numValid); else pass_cnt++;
      end
    end
    total_cnt++; if (bus.dispNum !== 16'h1A2F) $display("FAIL timeout_hold got %h want 1a2f", bus.dispNum); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] got;
    clear_mon();
    send_digit(0, 4'hE, 30);
    send_digit(1, 4'h2, 30);
    do_reset();
    send_digit(2, 4'hD, 30);
    send_digit(3, 4'h4, 30);
    send(4'hF, 7'h00, 30);
    total_cnt++; if (frames_q.size() != 0) $display("FAIL midreset_frames got %0d want 0", frames_q.size()); else pass_cnt++;
    total_cnt++; if (bus.dispNum !== 16'h0) $display("FAIL midreset_dispNum got %h want 0000", bus.dispNum); else pass_cnt++;
    send_value(16'h4D2E, 30);
    send(4'hF, 7'h00, 30);
    got = (frames_q.size() > 0) ? frames_q[0] : 16'hxxxx;
    total_cnt++; if (got !== 16'h4D2E) $display("FAIL midreset_rescan got %h want 4d2e", got); else pass_cnt++;
    total_cnt++; if (bus.numValid !== 1'b1) $display("FAIL midreset_numValid got %b want 1", bus.numValid); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [3:0]  m_stage [4];
    bit          m_mask [4];
    logic [15:0] exp_q [$];
    int          exp_glyph, exp_sel, kind, n, d, idx;
    logic [3:0]  sel;
    logic [6:0]  p;
    logic [10:0] prev;
    bit          long_hold;
    logic [15:0] got;
    do_reset();
    clear_mon();
    for (int k = 0; k < 4; k++) begin m_stage[k] = 4'h0; m_mask[k] = 1'b0; end
    exp_glyph = 0;
    exp_sel = 0;
    prev = {4'hF, 7'h00};
    for (int it = 0; it < 250; it++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7) begin
        sel = sel_of($urandom_range(0, 3));
        p = glyph_tab[$urandom_range(0, 15)];
      end else if (kind == 7) begin
        sel = sel_of($urandom_range(0, 3));
        do p = 7'($urandom_range(0, 127)); while (glyph_index(p) >= 0);
      end else if (kind == 8) begin
        do sel = 4'($urandom_range(0, 15)); while (sel == 4'hF || $countones(~sel) == 1);
        p = 7'($urandom_range(0, 127));
      end else begin
        sel = 4'hF;
        p = 7'($urandom_range(0, 127));
      end
      if ({sel, p} == prev) continue;
      long_hold = ($urandom_range(0, 3) != 0);
      n = long_hold ? $urandom_range(S + 4, S + 30) : $urandom_range(1, S - 4);
      send(sel, p, n);
      prev = {sel, p};
      if (!long_hold || sel == 4'hF) continue;
      if ($countones(~sel) != 1) begin
        exp_sel++;
        continue;
      end
      d = 0;
      for (int k = 0; k < 4; k++) if (!sel[k]) d = k;
      idx = glyph_index(p);
      if (idx < 0) begin
        exp_glyph++;
        m_mask[d] = 1'b0;
      end else begin
        m_stage[d] = 4'(idx);
        m_mask[d] = 1'b1;
        if (m_mask[0] && m_mask[1] && m_mask[2] && m_mask[3]) begin
          exp_q.push_back({m_stage[3], m_stage[2], m_stage[1], m_stage[0]});
          for (int k = 0; k < 4; k++) m_mask[k] = 1'b0;
        end
      end
    end
    send(4'hF, 7'h01, S + 10);
    total_cnt++; if (frames_q.size() != exp_q.size()) $display("FAIL random_frame_count got %0d want %0d", frames_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < frames_q.size()) ? frames_q[i] : 16'hxxxx;
      total_cnt++; if (got !== exp_q[i]) $display("FAIL random_frame_%0d got %h want %h", i, got, exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (glyph_seen != exp_glyph) $display("FAIL random_glyphErr got %0d want %0d", glyph_seen, exp_glyph); else pass_cnt++;
    total_cnt++; if (sel_seen != exp_sel) $display("FAIL random_selErr got %0d want %0d", sel_seen, exp_sel); else pass_cnt++;
    total_cnt++; if (double_pulse != 0) $display("FAIL random_double_pulse got %0d want 0", double_pulse); else pass_cnt++;
    total_cnt++; if (bus.numValid !== (exp_q.size() > 0)) $display("FAIL random_numValid got %b want %b", bus.numValid, exp_q.size() > 0); else pass_cnt++;
  endtask

  initial begin
    bus.segsel = 4'hF;
    bus.segments = 7'h7F;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_clean_scan();
    test_glitch();
    test_bad_glyph();
    test_bad_select();
    test_settle_boundary();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
